// File: rtl/load_comp_buffer.sv
// Load-completion buffer: queues loads returning from MEM/Complete and drains them
// in order to the ROB/CDB writeback port, absorbing writeback back-pressure.
module load_comp_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     in_lsq,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [PC_W-1:0]          out_pc,
   output logic                     out_lsq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic              lsq_mem  [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          full;
   logic          accept;

   assign push   = in_valid | in_lsq;
   assign full   = (count == FULL_CNT);
   assign pop    = out_valid & out_ready;
   // A full buffer still takes a new load when the head leaves on the same edge.
   assign accept = push & (~full | pop);

   assign out_valid = (count != '0);
   assign in_ready  = (count < FULL_CNT) | out_ready;

   // Storage is not reset; empty-state outputs are forced to zero instead.
   assign out_data = out_valid ? data_mem[rd_ptr] : '0;
   assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
   assign out_lsq  = out_valid ? lsq_mem[rd_ptr]  : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && accept) begin
         data_mem[wr_ptr] <= in_data;
         pc_mem[wr_ptr]   <= in_pc;
         lsq_mem[wr_ptr]  <= in_lsq;
      end
   end

endmodule

// File: tb/tb_load_comp_buffer.sv
// Scoreboard bench for load_comp_buffer: driver keeps an occupancy/queue model,
// monitor pops expected entries whenever the DUT hands one to writeback.
module tb_load_comp_buffer;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int PC_W   = 32;

   logic              clk = 0;
   logic              rst, flush, in_valid, in_lsq, in_ready, out_valid, out_ready, out_lsq, overflow;
   logic [DATA_W-1:0] in_data, out_data;
   logic [PC_W-1:0]   in_pc, out_pc;
   logic [$clog2(DEPTH):0] count;

   load_comp_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_lsq(in_lsq),
      .in_data(in_data), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc), .out_lsq(out_lsq),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [PC_W-1:0]   pc;
      logic              lsq;
   } entry_t;

   entry_t exp_q[$];
   int     occ     = 0;
   bit     exp_ovf = 0;
   bit     mon_en  = 0;
   int     n_chk   = 0;
   int     n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: state checks every cycle, data checks on each handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("count", 64'(count), 64'(occ));
         chk("out_valid", 64'(out_valid), 64'(occ != 0));
         chk("overflow", 64'(overflow), 64'(exp_ovf));
         chk("in_ready", 64'(in_ready), 64'((occ < DEPTH) || out_ready));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 64'(out_data), 64'hDEAD_0000);
            end else begin
               chk("out_data", 64'(out_data), 64'(exp_q[0].data));
               chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
               chk("out_lsq", 64'(out_lsq), 64'(exp_q[0].lsq));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // One clock: drive after the edge, then apply the coming edge to the model.
   task automatic cyc(input bit r, input bit fl, input bit iv, input bit il,
                      input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p, input bit ordy);
      bit pop, push;
      entry_t e;
      @(posedge clk); #1;
      rst = r; flush = fl; in_valid = iv; in_lsq = il;
      in_data = d; in_pc = p; out_ready = ordy;
      @(negedge clk); #1;
      pop  = ordy && (occ > 0);
      push = iv || il;
      if (r) begin
         exp_q.delete(); occ = 0; exp_ovf = 0;
      end else if (fl) begin
         exp_q.delete(); occ = 0;
      end else begin
         if (push && (occ < DEPTH || pop)) begin
            e.data = d; e.pc = p; e.lsq = il;
            exp_q.push_back(e);
            occ++;
         end else if (push) begin
            exp_ovf = 1;
         end
         if (pop) occ--;
      end
      mon_en = 1;
   endtask

   task automatic idle(input bit ordy, input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, '0, ordy);
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; in_lsq = 0; in_data = '0; in_pc = '0; out_ready = 0;

      // 1: reset held two cycles
      cyc(1, 0, 0, 0, '0, '0, 0);
      cyc(1, 0, 0, 0, '0, '0, 0);
      idle(0, 1);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_pc", 64'(out_pc), 64'h0);
      chk("rst_out_lsq", 64'(out_lsq), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);

      // 2: single pass-through
      cyc(0, 0, 1, 0, 32'h11, 32'h100, 1);
      idle(1, 2);

      // 3: fill with out_ready low, fifth load dropped
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 32'hA0 + i, 32'h200 + 4*i, 0);
      idle(0, 1);
      idle(1, 5);

      // 4: full buffer, push and pop on the same edge
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 32'hC0 + i, 32'h300 + 4*i, 0);
      cyc(0, 0, 1, 0, 32'hB0, 32'h400, 1);
      idle(1, 6);

      // 5: memory and LSQ valid together
      cyc(0, 0, 1, 1, 32'h55, 32'h500, 0);
      idle(0, 1);
      idle(1, 2);

      // 6: flush with a concurrent push at count 3
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, i[0], 32'hD0 + i, 32'h600 + 4*i, 0);
      cyc(0, 1, 1, 0, 32'hEE, 32'h700, 0);
      idle(1, 3);

      // Mid-operation reset with entries pending
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 32'hF0 + i, 32'h800 + 4*i, 0);
      cyc(1, 0, 1, 0, 32'hFF, 32'h900, 1);
      idle(1, 2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
             $urandom(), $urandom(), ($urandom_range(0, 9) < 5));
      end
      idle(1, DEPTH + 3);
      chk("drained", 64'(exp_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
